// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and the serial line idle level.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_rx_state_e;

   // Idle (mark) level of the serial line; also the synchronizer reset value.
   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver-side signal bundle: tick enable and serial line in, received word and status out.
interface uart_rx_param_if #(
   parameter int unsigned DATA_BITS = 8
);

   logic                 s_tick;
   logic                 rx;
   logic [DATA_BITS-1:0] dout;
   logic                 rx_done_tick;
   logic                 framing_err;
   logic                 parity_err;

   // master: the receive engine itself.
   modport master (
      input  s_tick,
      input  rx,
      output dout,
      output rx_done_tick,
      output framing_err,
      output parity_err
   );

   // slave: the baud generator / line driver and the consumer of received words.
   modport slave (
      output s_tick,
      output rx,
      input  dout,
      input  rx_done_tick,
      input  framing_err,
      input  parity_err
   );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, async active-low reset
// to a parameterised value.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receive engine advanced by s_tick; reports framing and parity status.
// Parity checking is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned STOP_BITS  = 1,
   parameter bit          PARITY_ODD = 1'b0
) (
   input logic             i_clk,
   input logic             i_reset,
   uart_rx_param_if.master bus
);

   localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W  = $clog2(DATA_BITS);

   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_param: DATA_BITS must be in 5..9");
   end
   if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
      $error("uart_rx_param: OVERSAMPLE must be even and at least 4");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_rx_param: STOP_BITS must be 1 or 2");
   end

   uart_rx_state_e       r_state;
   uart_rx_state_e       w_state_nxt;
   logic [TICK_W-1:0]    r_tick_cnt;
   logic [TICK_W-1:0]    w_tick_nxt;
   logic [BIT_W-1:0]     r_bit_cnt;
   logic [BIT_W-1:0]     w_bit_nxt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic                 r_ferr_acc;
   logic                 w_ferr_acc_nxt;
   logic                 w_frame_end;
   logic                 w_rx_s;

   logic [DATA_BITS-1:0] r_dout;
   logic                 r_done;
   logic                 r_ferr;

`ifdef UART_RX_PARITY_EN
   logic r_par_bit;
   logic w_par_nxt;
   logic w_par_err;
   logic r_perr;

   assign w_par_err = ((^r_shift) ^ r_par_bit) != PARITY_ODD;
`else
   logic w_unused_parity_odd;

   assign w_unused_parity_odd = PARITY_ODD;
`endif

   uart_sync2 #(
      .RESET_VAL (LINE_IDLE)
   ) u_sync_rx (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (bus.rx),
      .o_q     (w_rx_s)
   );

   // bit_cnt doubles as the stop-bit index once the data bits are in.
   always_comb begin
      w_state_nxt    = r_state;
      w_tick_nxt     = r_tick_cnt;
      w_bit_nxt      = r_bit_cnt;
      w_shift_nxt    = r_shift;
      w_ferr_acc_nxt = r_ferr_acc;
      w_frame_end    = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_nxt      = r_par_bit;
`endif
      if (bus.s_tick) begin
         unique case (r_state)
            IDLE: begin
               if (!w_rx_s) begin
                  w_state_nxt = START;
                  w_tick_nxt  = '0;
               end
            end
            START: begin
               if (r_tick_cnt == TICK_MID) begin
                  w_tick_nxt = '0;
                  if (!w_rx_s) begin
                     w_state_nxt    = DATA;
                     w_bit_nxt      = '0;
                     w_ferr_acc_nxt = 1'b0;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_tick_nxt = r_tick_cnt + 1'b1;
               end
            end
            DATA: begin
               if (r_tick_cnt == TICK_LAST) begin
                  w_tick_nxt  = '0;
                  w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                  if (r_bit_cnt == BIT_LAST) begin
                     w_bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
                     w_state_nxt = PARITY;
`else
                     w_state_nxt = STOP;
`endif
                  end else begin
                     w_bit_nxt = r_bit_cnt + 1'b1;
                  end
               end else begin
                  w_tick_nxt = r_tick_cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (r_tick_cnt == TICK_LAST) begin
                  w_tick_nxt  = '0;
                  w_par_nxt   = w_rx_s;
                  w_state_nxt = STOP;
               end else begin
                  w_tick_nxt = r_tick_cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (r_tick_cnt == TICK_LAST) begin
                  w_tick_nxt     = '0;
                  w_ferr_acc_nxt = r_ferr_acc | ~w_rx_s;
                  if (r_bit_cnt == STOP_LAST) begin
                     // Leave at the stop-bit midpoint for half a bit of resync margin.
                     w_bit_nxt   = '0;
                     w_state_nxt = IDLE;
                     w_frame_end = 1'b1;
                  end else begin
                     w_bit_nxt = r_bit_cnt + 1'b1;
                  end
               end else begin
                  w_tick_nxt = r_tick_cnt + 1'b1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_tick_nxt  = '0;
               w_bit_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= IDLE;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit  <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_tick_cnt <= w_tick_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
         r_ferr_acc <= w_ferr_acc_nxt;
`ifdef UART_RX_PARITY_EN
         r_par_bit  <= w_par_nxt;
`endif
      end
   end

   // Word and status are published together with the one-clk completion pulse.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_dout <= '0;
         r_done <= 1'b0;
         r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_perr <= 1'b0;
`endif
      end else begin
         r_done <= w_frame_end;
         if (w_frame_end) begin
            r_dout <= r_shift;
            r_ferr <= w_ferr_acc_nxt;
`ifdef UART_RX_PARITY_EN
            r_perr <= w_par_err;
`endif
         end
      end
   end

   assign bus.dout         = r_dout;
   assign bus.rx_done_tick = r_done;
   assign bus.framing_err  = r_ferr;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err   = r_perr;
`else
   assign bus.parity_err   = 1'b0;
`endif

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receive engine: the next-generation successor to the fixed 8N1 receiver in the UART subsystem. It runs on the system clock, uses the baud generator's `s_tick` as a clock enable, and resolves asynchronous `rx` through a synchronizer. Data width, oversampling ratio and stop-bit count are configurable. It validates the start bit and reports framing and optional parity errors alongside each received word.

## Interface
- `DATA_BITS`, 8: payload bits per frame; legal range 5..9.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit period; even, at least 4.
- `STOP_BITS`, 1: stop bits checked per frame; legal values 1 or 2.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Only used when `UART_RX_PARITY_EN` is defined.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `s_tick`  in  1  one-`clk`-wide enable pulse, OVERSAMPLE per bit.
- `rx`  in  1  asynchronous serial line; idle high.
- `dout`  out  DATA_BITS  last received word, LSB first on the line.
- `rx_done_tick`  out  1  one-`clk` pulse per completed frame.
- `framing_err`  out  1  a stop-bit sample of the last frame was 0.
- `parity_err`  out  1  parity mismatch on the last frame; tied 0 when parity is compiled out.

## Operation
- `rx` passes through a 2-flop synchronizer, reset value 1, giving `rx_s`. All decisions use `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP. Everything except the synchronizer advances only on `clk` edges where `s_tick`=1.
- IDLE: when `rx_s`=0, go to START with `tick_cnt`=0.
- START: increment `tick_cnt`. At `tick_cnt`==OVERSAMPLE/2-1 (the start-bit midpoint):
  - if `rx_s`=0, go to DATA with `tick_cnt`=0 and `bit_cnt`=0;
  - if `rx_s`=1, treat as a false start and return to IDLE. There is no `rx_done_tick` and no flag change.
- DATA: at `tick_cnt`==OVERSAMPLE-1, shift `rx_s` into the MSB of the shift register (LSB-first reassembly) and clear `tick_cnt`. When `bit_cnt`==DATA_BITS-1, go to PARITY if parity is enabled, otherwise to STOP. Otherwise increment `bit_cnt`.
- PARITY: at `tick_cnt`==OVERSAMPLE-1, capture the parity bit and go to STOP.
- STOP: at `tick_cnt`==OVERSAMPLE-1, sample the stop bit. Any stop sample equal to 0 sets a sticky per-frame framing error.
  - If more stop bits remain, stay in STOP.
  - After the last stop bit, return to IDLE. This happens at the stop-bit midpoint, giving half a bit of resync margin.
- Frame completion, all on the same edge:
  - `dout` ← shift register;
  - `framing_err` and `parity_err` are updated for this frame;
  - `rx_done_tick` is registered high for exactly one `clk` cycle.
- `dout` and both flags hold until the next frame completes. A frame with a framing error still updates `dout`.
- Counter widths: `tick_cnt` is $clog2(OVERSAMPLE) bits and `bit_cnt` is $clog2(DATA_BITS) bits. Neither counter ever wraps, because each is cleared at its terminal value.

## Timing
- Reset values: `dout`=0, `rx_done_tick`=0, `framing_err`=0, `parity_err`=0, state IDLE, counters 0, synchronizer flops 1.
- Asserting `reset` mid-frame aborts the frame immediately. No `rx_done_tick` is produced and outputs return to their reset values.
- Latency from the `rx` falling edge to `rx_done_tick` is 2 `clk` (synchronizer), plus ≤1 tick of detection, plus these tick counts:
  - OVERSAMPLE/2, to the start-bit midpoint;
  - OVERSAMPLE × (DATA_BITS + P + STOP_BITS), where P=1 with parity, else 0;
  - plus 1 `clk` for the registered pulse.
- Back-to-back frames: a new start edge is accepted on the first `s_tick` after returning to IDLE. There are no dead ticks.
- `rx_done_tick` never coincides with reset and is never wider than one `clk`, whatever the `s_tick` spacing.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - the PARITY state exists, and frames carry one parity bit after the data;
  - `parity_err` = (XOR of data bits and parity bit) != PARITY_ODD.
- `UART_RX_PARITY_EN` undefined:
  - the PARITY state and parity logic are absent;
  - DATA goes directly to STOP, and `parity_err` is constant 0.

## Structure
- Package `uart_pkg` holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP;
  - the shared reset value for the line idle level (1), which the transmitter also uses.
- Sub-module `uart_sync2`: a 2-flop synchronizer with async active-low reset to a parameterised value. It is reused by other UART blocks.

## Test plan
- 8N1, OVERSAMPLE=16, send 0xA5 → `dout`=0xA5, one `rx_done_tick`, `framing_err`=0, `parity_err`=0.
- Drive `rx` low for 4 ticks then high → no `rx_done_tick`, state back in IDLE, `dout` unchanged.
- Send 0x3C with stop bit driven 0 → `dout`=0x3C, `framing_err`=1. The next frame, 0x55 with a valid stop bit, gives `framing_err`=0.
- With `UART_RX_PARITY_EN` and PARITY_ODD=0, send 0x07 with parity bit 0 → `parity_err`=1. The same word with parity bit 1 gives `parity_err`=0.
- DATA_BITS=7, STOP_BITS=2, back-to-back 0x41 then 0x7F with no idle gap → two pulses spaced exactly 10×16 ticks apart. `dout`=0x41 then 0x7F.
- Assert `reset` during data bit 4 of 0xFF → all outputs at reset values, no pulse. The following frame 0x12 is received correctly.
